// File: rtl/pc_unit_if.sv
// pc_unit_if: groups the control-unit / ALU side of the program-counter unit.
// The master modport is the control unit (drives requests and the target);
// the slave modport is pc_unit (returns the fetch address and stack status).
interface pc_unit_if #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
);
    logic                               stall;
    logic                               pc_write;
    logic                               branch_eq;
    logic                               branch_ne;
    logic                               is_zero;
    logic                               call;
    logic                               ret;
    logic [WIDTH-1:0]                   target;
    logic [WIDTH-1:0]                   pc;
    logic [WIDTH-1:0]                   pc_seq;
    logic                               redirect;
    logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth;
    logic                               stack_full;
    logic                               stack_empty;
    logic                               fault;

    modport master (
        output stall, pc_write, branch_eq, branch_ne, is_zero, call, ret, target,
        input  pc, pc_seq, redirect, stack_depth, stack_full, stack_empty, fault
    );

    modport slave (
        input  stall, pc_write, branch_eq, branch_ne, is_zero, call, ret, target,
        output pc, pc_seq, redirect, stack_depth, stack_full, stack_empty, fault
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential advance, jumps, equal/not-equal
// branches on the ALU zero flag, and calls/returns through an internal
// return-address stack.
// Optional feature macro: PC_UNIT_RAS_EN. When it is defined the return-address
// stack, call push / ret pop and the sticky fault flag are built. When it is
// undefined there is no stack: call acts as a plain jump, ret is ignored, and
// the stack status outputs are tied to "empty, never faulted".
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter int               INC          = 2,
    parameter int               STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic       clock,
    input logic       reset_n,
    pc_unit_if.slave  bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic             redirect_q;
    logic [WIDTH-1:0] pc_seq;
    logic             taken;

    assign pc_seq = pc_q + WIDTH'(INC);
    assign taken  = (bus.branch_eq & bus.is_zero) | (bus.branch_ne & ~bus.is_zero);

`ifdef PC_UNIT_RAS_EN
    localparam int PW = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] ras [STACK_DEPTH];
    logic [DW-1:0]    depth_q;
    logic             fault_q;
    logic             full;
    logic             empty;
    logic             push;
    logic [WIDTH-1:0] top;

    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign top   = ras[PW'(depth_q - DW'(1))];
    assign push  = reset_n & ~bus.stall & ~bus.ret & bus.call & ~full;

    // Stack storage: contents need no reset, only the occupancy counter does
    always_ff @(posedge clock) begin
        if (push) begin
            ras[PW'(depth_q)] <= pc_seq;
        end
    end

    // PC, occupancy and fault update in priority order: stall, ret, call, jump, branch, sequential
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            depth_q    <= '0;
            fault_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else if (bus.stall) begin
            redirect_q <= 1'b0;
        end else if (bus.ret) begin
            if (!empty) begin
                pc_q       <= top;
                depth_q    <= depth_q - DW'(1);
                redirect_q <= 1'b1;
            end else begin
                pc_q       <= pc_seq;
                fault_q    <= 1'b1;
                redirect_q <= 1'b0;
            end
        end else if (bus.call) begin
            pc_q       <= bus.target;
            redirect_q <= 1'b1;
            if (!full) begin
                depth_q <= depth_q + DW'(1);
            end else begin
                fault_q <= 1'b1;
            end
        end else if (bus.pc_write || taken) begin
            pc_q       <= bus.target;
            redirect_q <= 1'b1;
        end else begin
            pc_q       <= pc_seq;
            redirect_q <= 1'b0;
        end
    end

    assign bus.stack_depth = depth_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.fault       = fault_q;
`else
    logic unused_ret;

    assign unused_ret = bus.ret;

    // PC update without a stack: call is just another jump, ret never takes effect
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            redirect_q <= 1'b0;
        end else if (bus.stall) begin
            redirect_q <= 1'b0;
        end else if (bus.call || bus.pc_write || taken) begin
            pc_q       <= bus.target;
            redirect_q <= 1'b1;
        end else begin
            pc_q       <= pc_seq;
            redirect_q <= 1'b0;
        end
    end

    assign bus.stack_depth = '0;
    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.fault       = 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_seq   = pc_seq;
    assign bus.redirect = redirect_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven bench for pc_unit with WIDTH=16, INC=2,
// STACK_DEPTH=4, RESET_VECTOR=0. The stack section follows PC_UNIT_RAS_EN.
module tb_pc_unit;
    logic clock;
    logic reset_n;

    int assertCount = 0;
    int failCount   = 0;

    pc_unit_if #(.WIDTH(16), .STACK_DEPTH(4)) bus ();

    pc_unit #(
        .WIDTH(16),
        .INC(2),
        .STACK_DEPTH(4),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        pw;
        logic        beq;
        logic        bne;
        logic        zero;
        logic        call;
        logic        ret;
        logic [15:0] target;
        logic [15:0] expPc;
        logic        expRed;
        logic [2:0]  expDepth;
        logic        expFault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(string n, logic r, logic st, logic pw, logic beq,
                                   logic bne, logic z, logic c, logic rt, logic [15:0] t,
                                   logic [15:0] ep, logic er, logic [2:0] ed, logic ef);
        vec_t v;
        v.name = n; v.rst = r; v.stall = st; v.pw = pw; v.beq = beq; v.bne = bne;
        v.zero = z; v.call = c; v.ret = rt; v.target = t;
        v.expPc = ep; v.expRed = er; v.expDepth = ed; v.expFault = ef;
        return v;
    endfunction

    task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name, logic [15:0] ep, logic er, logic [2:0] ed, logic ef);
        cmp({name, ".pc"},          bus.pc, ep);
        cmp({name, ".pc_seq"},      bus.pc_seq, ep + 16'd2);
        cmp({name, ".redirect"},    16'(bus.redirect), 16'(er));
        cmp({name, ".stack_depth"}, 16'(bus.stack_depth), 16'(ed));
        cmp({name, ".stack_full"},  16'(bus.stack_full), 16'(ed == 3'd4));
        cmp({name, ".stack_empty"}, 16'(bus.stack_empty), 16'(ed == 3'd0));
        cmp({name, ".fault"},       16'(bus.fault), 16'(ef));
    endtask

    task automatic applyStimulus(vec_t v);
        reset_n       = ~v.rst;
        bus.stall     = v.stall;
        bus.pc_write  = v.pw;
        bus.branch_eq = v.beq;
        bus.branch_ne = v.bne;
        bus.is_zero   = v.zero;
        bus.call      = v.call;
        bus.ret       = v.ret;
        bus.target    = v.target;
        @(posedge clock);
        #1;
        checkOutput(v.name, v.expPc, v.expRed, v.expDepth, v.expFault);
    endtask

    initial begin
        // Power-on reset, two edges, then check the reset state
        applyStimulus(mkVec("reset0", 1, 0,0,0,0,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));
        applyStimulus(mkVec("reset1", 1, 0,0,0,0,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));

        // Sequential advance, jumps and branch decode
        //                   name      rst st pw eq ne z  c  r  target    expPc   red dep flt
        vecs.push_back(mkVec("idle1",   0, 0,0,0,0,0,0,0, 16'h0000, 16'h0002, 0, 0, 0));
        vecs.push_back(mkVec("idle2",   0, 0,0,0,0,0,0,0, 16'h0000, 16'h0004, 0, 0, 0));
        vecs.push_back(mkVec("idle3",   0, 0,0,0,0,0,0,0, 16'h0000, 16'h0006, 0, 0, 0));
        vecs.push_back(mkVec("jmp10",   0, 0,1,0,0,0,0,0, 16'h0010, 16'h0010, 1, 0, 0));
        vecs.push_back(mkVec("beqNt",   0, 0,0,1,0,0,0,0, 16'h0080, 16'h0012, 0, 0, 0));
        vecs.push_back(mkVec("bneTk",   0, 0,0,0,1,0,0,0, 16'h0040, 16'h0040, 1, 0, 0));
        vecs.push_back(mkVec("afterBr", 0, 0,0,0,0,0,0,0, 16'h0000, 16'h0042, 0, 0, 0));
        vecs.push_back(mkVec("beqTk",   0, 0,0,1,0,1,0,0, 16'h0100, 16'h0100, 1, 0, 0));
        vecs.push_back(mkVec("bneNt",   0, 0,0,0,1,1,0,0, 16'h0200, 16'h0102, 0, 0, 0));
        vecs.push_back(mkVec("bothZ1",  0, 0,0,1,1,1,0,0, 16'h0300, 16'h0300, 1, 0, 0));
        vecs.push_back(mkVec("bothZ0",  0, 0,0,1,1,0,0,0, 16'h0400, 16'h0400, 1, 0, 0));
        vecs.push_back(mkVec("jmpTop",  0, 0,1,0,0,0,0,0, 16'hFFFE, 16'hFFFE, 1, 0, 0));
        vecs.push_back(mkVec("wrap",    0, 0,0,0,0,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Stall held three cycles with a pending jump: nothing moves
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkVec($sformatf("stall%0d", k), 0, 1,1,0,0,0,0,0, 16'h1234, 16'h0000, 0, 0, 0));
        end
        applyStimulus(mkVec("jmp20",     0, 0,1,0,0,0,0,0, 16'h0020, 16'h0020, 1, 0, 0));
        applyStimulus(mkVec("stallRed",  0, 1,0,0,0,0,0,0, 16'h0000, 16'h0020, 0, 0, 0));

        vecs.delete();
`ifdef PC_UNIT_RAS_EN
        // Nested call / return, then call+ret collision
        vecs.push_back(mkVec("call100", 0, 0,0,0,0,0,1,0, 16'h0100, 16'h0100, 1, 1, 0));
        vecs.push_back(mkVec("call200", 0, 0,0,0,0,0,1,0, 16'h0200, 16'h0200, 1, 2, 0));
        vecs.push_back(mkVec("ret1",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0102, 1, 1, 0));
        vecs.push_back(mkVec("ret2",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0022, 1, 0, 0));
        vecs.push_back(mkVec("call500", 0, 0,0,0,0,0,1,0, 16'h0500, 16'h0500, 1, 1, 0));
        vecs.push_back(mkVec("callRet", 0, 0,0,0,0,0,1,1, 16'h0600, 16'h0024, 1, 0, 0));
        // Fill the stack, overflow, stall over a pending ret
        vecs.push_back(mkVec("callA",   0, 0,0,0,0,0,1,0, 16'h0300, 16'h0300, 1, 1, 0));
        vecs.push_back(mkVec("stallRt", 0, 1,0,0,0,0,0,1, 16'h0000, 16'h0300, 0, 1, 0));
        vecs.push_back(mkVec("callB",   0, 0,0,0,0,0,1,0, 16'h0310, 16'h0310, 1, 2, 0));
        vecs.push_back(mkVec("callC",   0, 0,0,0,0,0,1,0, 16'h0320, 16'h0320, 1, 3, 0));
        vecs.push_back(mkVec("callD",   0, 0,0,0,0,0,1,0, 16'h0330, 16'h0330, 1, 4, 0));
        vecs.push_back(mkVec("callOvf", 0, 0,0,0,0,0,1,0, 16'h0340, 16'h0340, 1, 4, 1));
        vecs.push_back(mkVec("popD",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0322, 1, 3, 1));
        vecs.push_back(mkVec("popC",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0312, 1, 2, 1));
        vecs.push_back(mkVec("popB",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0302, 1, 1, 1));
        vecs.push_back(mkVec("popA",    0, 0,0,0,0,0,0,1, 16'h0000, 16'h0026, 1, 0, 1));
        vecs.push_back(mkVec("retUnf",  0, 0,0,0,0,0,0,1, 16'h0000, 16'h0028, 0, 0, 1));
        vecs.push_back(mkVec("sticky",  0, 0,0,0,0,0,0,0, 16'h0000, 16'h002A, 0, 0, 1));
        // Reset during a stall with the stack occupied clears everything
        vecs.push_back(mkVec("call700", 0, 0,0,0,0,0,1,0, 16'h0700, 16'h0700, 1, 1, 1));
        vecs.push_back(mkVec("rstStal", 1, 1,0,0,0,0,1,1, 16'h0900, 16'h0000, 0, 0, 0));
        vecs.push_back(mkVec("postRst", 0, 0,0,0,0,0,0,0, 16'h0000, 16'h0002, 0, 0, 0));
`else
        // No stack: call is a jump, ret is ignored
        vecs.push_back(mkVec("call300", 0, 0,0,0,0,0,1,0, 16'h0300, 16'h0300, 1, 0, 0));
        vecs.push_back(mkVec("retIgn",  0, 0,0,0,0,0,0,1, 16'h0000, 16'h0302, 0, 0, 0));
        vecs.push_back(mkVec("retJmp",  0, 0,1,0,0,0,0,1, 16'h0400, 16'h0400, 1, 0, 0));
        vecs.push_back(mkVec("callRet", 0, 0,0,0,0,0,1,1, 16'h0500, 16'h0500, 1, 0, 0));
        vecs.push_back(mkVec("retBr",   0, 0,0,1,0,1,0,1, 16'h0600, 16'h0600, 1, 0, 0));
        vecs.push_back(mkVec("rstStal", 1, 1,0,0,0,0,1,1, 16'h0900, 16'h0000, 0, 0, 0));
        vecs.push_back(mkVec("postRst", 0, 0,0,0,0,0,0,0, 16'h0000, 16'h0002, 0, 0, 0));
`endif
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
